// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit bridging a RISC-V core to a single-beat memory port.
// One access in flight; the request is latched in IDLE, and the memory side is
// driven only from those latches. Load data is lane-shifted and extended on
// return. Each memory handshake phase is guarded by a cycle-count timeout.
module riscv_lsu #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 32'hFFFF_FC00,
    parameter int                TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_misalign,
    output logic                resp_timeout,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rvalid,
    output logic                is_mmio
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                memWe_q, memWe_d;
    logic                loadUnsigned_q, loadUnsigned_d;
    logic [1:0]          size_q, size_d;
    logic [OFF_W-1:0]    offset_q, offset_d;
    logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
    logic [NB-1:0]       memBe_q, memBe_d;
    logic [DATA_W-1:0]   memWdata_q, memWdata_d;
    logic                isMmio_q, isMmio_d;
    logic                misalign_q, misalign_d;
    logic                timeout_q, timeout_d;
    logic [DATA_W-1:0]   respRdata_q, respRdata_d;

    logic [OFF_W-1:0]    reqOff;
    int                  reqBytes;
    logic                reqMisalign;
    logic [NB-1:0]       sizeMask;
    logic [DATA_W-1:0]   wdataMasked;
    logic [NB-1:0]       reqBe;
    logic [DATA_W-1:0]   reqWdata;
    logic [ADDR_W-1:0]   reqAddrAligned;
    logic                reqMmio;

    logic [DATA_W-1:0]   shiftedRdata;
    int                  loadBits;
    logic                signBit;
    logic [DATA_W-1:0]   loadData;

    // Decode the incoming request into lane enables, aligned write data and legality.
    always_comb begin
        reqOff      = req_addr[OFF_W-1:0];
        reqBytes    = 32'd1 << req_size;
        reqMisalign = 1'b0;
        unique case (req_size)
            2'd0:    reqMisalign = 1'b0;
            2'd1:    reqMisalign = req_addr[0];
            2'd2:    reqMisalign = (req_addr[1:0] != 2'b00);
            default: reqMisalign = (DATA_W == 32) || (req_addr[2:0] != 3'b000);
        endcase
        sizeMask    = '0;
        wdataMasked = '0;
        for (int b = 0; b < NB; b++) begin
            sizeMask[b]          = (b < reqBytes);
            wdataMasked[8*b +: 8] = (b < reqBytes) ? req_wdata[8*b +: 8] : 8'h00;
        end
        reqBe                      = sizeMask << reqOff;
        reqWdata                   = wdataMasked << {reqOff, 3'b000};
        reqAddrAligned             = req_addr;
        reqAddrAligned[OFF_W-1:0]  = '0;
        reqMmio                    = (req_addr >= MMIO_BASE);
    end

    // Shift returning data down to bit 0 and sign- or zero-extend from the access width.
    always_comb begin
        shiftedRdata = mem_rdata >> {offset_q, 3'b000};
        loadBits     = 32'd8 << size_q;
        if (loadBits > DATA_W) begin
            loadBits = DATA_W;
        end
        signBit = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == loadBits - 1) begin
                signBit = shiftedRdata[i];
            end
        end
        loadData = '0;
        for (int i = 0; i < DATA_W; i++) begin
            loadData[i] = (i < loadBits) ? shiftedRdata[i] : (signBit & ~loadUnsigned_q);
        end
    end

    // Next-state logic: latch in IDLE, handshake with timeout in ISSUE/WAIT, one-cycle DONE.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        memWe_d        = memWe_q;
        loadUnsigned_d = loadUnsigned_q;
        size_d         = size_q;
        offset_d       = offset_q;
        memAddr_d      = memAddr_q;
        memBe_d        = memBe_q;
        memWdata_d     = memWdata_q;
        isMmio_d       = isMmio_q;
        misalign_d     = misalign_q;
        timeout_d      = timeout_q;
        respRdata_d    = respRdata_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    memWe_d        = req_we;
                    loadUnsigned_d = req_unsigned;
                    size_d         = req_size;
                    offset_d       = reqOff;
                    memAddr_d      = reqAddrAligned;
                    memBe_d        = reqBe;
                    memWdata_d     = reqWdata;
                    isMmio_d       = reqMmio;
                    misalign_d     = reqMisalign;
                    timeout_d      = 1'b0;
                    count_d        = '0;
                    state_d        = reqMisalign ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    count_d = '0;
                    state_d = memWe_q ? DONE : WAIT;
                end else if (count_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    respRdata_d = loadData;
                    state_d     = DONE;
                end else if (count_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers; reset abandons any access in flight without a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            count_q        <= '0;
            memWe_q        <= 1'b0;
            loadUnsigned_q <= 1'b0;
            size_q         <= 2'd0;
            offset_q       <= '0;
            memAddr_q      <= '0;
            memBe_q        <= '0;
            memWdata_q     <= '0;
            isMmio_q       <= 1'b0;
            misalign_q     <= 1'b0;
            timeout_q      <= 1'b0;
            respRdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            memWe_q        <= memWe_d;
            loadUnsigned_q <= loadUnsigned_d;
            size_q         <= size_d;
            offset_q       <= offset_d;
            memAddr_q      <= memAddr_d;
            memBe_q        <= memBe_d;
            memWdata_q     <= memWdata_d;
            isMmio_q       <= isMmio_d;
            misalign_q     <= misalign_d;
            timeout_q      <= timeout_d;
            respRdata_q    <= respRdata_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign mem_valid     = (state_q == ISSUE);
    assign resp_valid    = (state_q == DONE);
    assign resp_misalign = (state_q == DONE) & misalign_q;
    assign resp_timeout  = (state_q == DONE) & timeout_q;
    assign resp_rdata    = respRdata_q;
    assign mem_we        = memWe_q;
    assign mem_be        = memBe_q;
    assign mem_addr      = memAddr_q;
    assign mem_wdata     = memWdata_q;
    assign is_mmio       = isMmio_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: randomized and directed bench for riscv_lsu (32-bit bus, TIMEOUT=4).
// The stimulus side plays both core and memory and pushes each expected response;
// a separate monitor pops and compares whenever resp_valid is seen.
module tb_riscv_lsu;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int TB_TIMEOUT = 4;

    logic                clk;
    logic                rst;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [1:0]          req_size;
    logic                req_unsigned;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic                resp_valid;
    logic [DATA_W-1:0]   resp_rdata;
    logic                resp_misalign;
    logic                resp_timeout;
    logic                mem_valid;
    logic                mem_ready;
    logic                mem_we;
    logic [DATA_W/8-1:0] mem_be;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_rvalid;
    logic                is_mmio;

    riscv_lsu #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MMIO_BASE(32'hFFFF_FC00),
        .TIMEOUT  (TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_misalign(resp_misalign),
        .resp_timeout (resp_timeout),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .is_mmio      (is_mmio)
    );

    typedef struct {
        bit          misalign;
        bit          timeout;
        logic [31:0] rdata;
    } resp_t;

    resp_t       expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] modelRdata = '0;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the DUT wedges somewhere the bounded loops cannot see.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at time %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model of access legality on a 32-bit bus.
    function automatic bit modelMisalign(input logic [1:0] size, input logic [31:0] addr);
        longint unsigned a;
        longint unsigned k;
        a = 64'(addr);
        k = 64'd1 << size;
        if (size == 2'd3) return 1'b1;
        return (a % k) != 0;
    endfunction

    // Reference model of load extraction: pick k bytes at the offset, then extend.
    function automatic logic [31:0] modelLoad(input logic [31:0] rdata, input logic [1:0] size,
                                              input bit uns, input int off);
        longint unsigned v;
        longint unsigned span;
        int bits;
        bits = 8 * (1 << size);
        span = 64'd1 << bits;
        v = (64'(rdata) >> (8 * off)) % span;
        if (!uns && v >= (span >> 1)) v = v - span;
        return v[31:0];
    endfunction

    // Drive one access as core and memory; pushes the expected response and checks the memory side.
    task automatic applyStimulus(input bit we, input logic [1:0] size, input bit uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int readyDelay,
                                 input int rvalidDelay, input bit lateRvalid);
        bit          mis;
        bit          tmo;
        bit          done;
        int          k;
        int          off;
        int          cyc;
        logic [31:0] expBe;
        logic [63:0] expWdata;
        logic [31:0] expAddr;
        bit          expMmio;

        mis      = modelMisalign(size, addr);
        k        = 1 << size;
        off      = int'(addr % 32'd4);
        tmo      = !mis && (readyDelay >= TB_TIMEOUT || (!we && rvalidDelay >= TB_TIMEOUT));
        expBe    = ((32'd1 << k) - 32'd1) << off;
        expWdata = (64'(wdata) & ((64'd1 << (8 * k)) - 64'd1)) << (8 * off);
        expAddr  = addr - 32'(off);
        expMmio  = (64'(addr) >= 64'hFFFF_FC00);
        if (!we && !mis && !tmo) modelRdata = modelLoad(rdata, size, uns, off);

        checkOutput("reqReadyIdle", req_ready, 1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        expQ.push_back('{mis, tmo, modelRdata});
        @(negedge clk);
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;

        if (mis) begin
            checkOutput("misalignNoMemValid", mem_valid, 0);
            checkOutput("misalignLatency", resp_valid, 1);
            @(negedge clk);
            return;
        end

        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < TB_TIMEOUT) begin
            checkOutput("issueMemValid", mem_valid, 1);
            checkOutput("issueNoResp", resp_valid, 0);
            checkOutput("issueReqReady", req_ready, 0);
            checkOutput("issueMemWe", mem_we, we);
            checkOutput("issueMemBe", mem_be, expBe[3:0]);
            checkOutput("issueMemAddr", mem_addr, expAddr);
            checkOutput("issueMemWdata", mem_wdata, expWdata[31:0]);
            checkOutput("issueIsMmio", is_mmio, expMmio);
            if (cyc == readyDelay) begin
                mem_ready  = 1'b1;
                mem_rvalid = 1'b0;
                done       = 1'b1;
            end else begin
                mem_rvalid = 1'($urandom);
                mem_rdata  = $urandom;
            end
            @(negedge clk);
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            cyc++;
        end

        if (done && !we) begin
            cyc  = 0;
            done = 1'b0;
            while (!done && cyc < TB_TIMEOUT) begin
                checkOutput("waitMemValid", mem_valid, 0);
                checkOutput("waitNoResp", resp_valid, 0);
                if (cyc == rvalidDelay) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdata;
                    done       = 1'b1;
                end else begin
                    mem_rdata = $urandom;
                end
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
                cyc++;
            end
        end

        checkOutput("doneMemValid", mem_valid, 0);
        checkOutput("doneRespValid", resp_valid, 1);
        if (tmo && lateRvalid) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    // Start a load and hit reset mid-ISSUE or mid-WAIT; no response is expected.
    task automatic abortTxn(input bit inWait);
        checkOutput("abortReqReady", req_ready, 1);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 32'h0000_0204;
        req_wdata    = 32'h5555_AAAA;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("abortIssueValid", mem_valid, 1);
        if (inWait) begin
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
            checkOutput("abortWaitReqReady", req_ready, 0);
        end
        #2;
        rst = 1'b1;
        #1;
        modelRdata = '0;
        checkOutput("abortMemValid", mem_valid, 0);
        checkOutput("abortReqReadyAsync", req_ready, 1);
        checkOutput("abortMemBe", mem_be, 0);
        checkOutput("abortMemAddr", mem_addr, 0);
        checkOutput("abortRespRdata", resp_rdata, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("abortNoResp", resp_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abortNoRespAfter", resp_valid, 0);
    endtask

    // Scoreboard monitor: every completion pulse must match the oldest expected response.
    always @(negedge clk) begin
        resp_t want;
        if (!rst && resp_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedResp", 1, 0);
            end else begin
                want = expQ.pop_front();
                checkOutput("respMisalign", resp_misalign, want.misalign);
                checkOutput("respTimeout", resp_timeout, want.timeout);
                checkOutput("respRdata", resp_rdata, want.rdata);
            end
        end
    end

    initial begin
        logic [1:0]  size;
        logic [31:0] addr;
        int          k;
        int          rd;
        int          vd;

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        mem_ready    = 1'b0;
        mem_rdata    = '0;
        mem_rvalid   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstReqReady", req_ready, 1);
        checkOutput("rstRespValid", resp_valid, 0);
        checkOutput("rstRespMisalign", resp_misalign, 0);
        checkOutput("rstRespTimeout", resp_timeout, 0);
        checkOutput("rstMemValid", mem_valid, 0);
        checkOutput("rstMemWe", mem_we, 0);
        checkOutput("rstIsMmio", is_mmio, 0);
        checkOutput("rstMemBe", mem_be, 0);
        checkOutput("rstMemAddr", mem_addr, 0);
        checkOutput("rstMemWdata", mem_wdata, 0);
        checkOutput("rstRespRdata", resp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed accesses");
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, 0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, 0, 1'b0);
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 0, 0, 1'b0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0106, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        applyStimulus(1'b0, 2'd3, 1'b0, 32'h0000_0108, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0110, 32'h0, 32'h1357_9BDF, 10, 0, 1'b1);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h0000_0112, 32'h0, 32'hF00D_CAFE, 0, 10, 1'b1);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0114, 32'h0, 32'h2468_ACE0, 0, 0, 1'b0);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'hFFFF_FC60, 32'hCAFE_F00D, 32'h0, 1, 0, 1'b0);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h0000_0060, 32'hCAFE_F00D, 32'h0, 3, 0, 1'b0);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h0000_0122, 32'h0, 32'h8001_7FFF, 2, 3, 1'b0);

        $display("[TB] reset during an access");
        abortTxn(1'b0);
        abortTxn(1'b1);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h0000_0132, 32'h0, 32'h9ABC_1234, 0, 0, 1'b0);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 150; n++) begin
            size = 2'($urandom_range(0, 3));
            k    = 1 << size;
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr - (addr % 32'(k));
            if ($urandom_range(0, 4) == 0) addr[31:10] = '1;
            rd = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 6));
            vd = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 6));
            applyStimulus(1'($urandom), size, 1'($urandom), addr, $urandom, $urandom,
                          rd, vd, 1'($urandom));
        end

        @(negedge clk);
        checkOutput("queueDrained", 64'(expQ.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter DATA_W, default 32, is the data path width; legal values are 32 and 64.
REQ-003 Parameter ADDR_W, default 32, is the byte address width.
REQ-004 Parameter MMIO_BASE, default 32'hFFFF_FC00, is the lowest MMIO byte address.
REQ-005 Parameter TIMEOUT, default 255, is the maximum wait in cycles per handshake phase; its range is 2..65535.
REQ-006 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 Port req_valid, input, 1 bit: core access request.
REQ-009 Port req_ready, output, 1 bit: the LSU accepts a request this cycle.
REQ-010 Port req_we, input, 1 bit: 1 selects store, 0 selects load.
REQ-011 Port req_size, input, 2 bits: 0 byte, 1 half, 2 word, 3 double (double legal only when DATA_W=64).
REQ-012 Port req_unsigned, input, 1 bit: selects zero-extension on loads.
REQ-013 Port req_addr, input, ADDR_W bits: byte address.
REQ-014 Port req_wdata, input, DATA_W bits: store data, right-aligned.
REQ-015 Port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-016 Port resp_rdata, output, DATA_W bits: extended load data.
REQ-017 Port resp_misalign, output, 1 bit: error flag, valid with resp_valid.
REQ-018 Port resp_timeout, output, 1 bit: error flag, valid with resp_valid.
REQ-019 Port mem_valid, output, 1 bit: memory request.
REQ-020 Port mem_ready, input, 1 bit: memory accepts the request.
REQ-021 Port mem_we, output, 1 bit; port mem_be, output, DATA_W/8 bits, byte enables.
REQ-022 Port mem_addr, output, ADDR_W bits: req_addr with its low log2(DATA_W/8) bits forced to 0.
REQ-023 Port mem_wdata, output, DATA_W bits; port mem_rdata, input, DATA_W bits.
REQ-024 Port mem_rvalid, input, 1 bit: mem_rdata is valid.
REQ-025 Port is_mmio, output, 1 bit: the latched address is >= MMIO_BASE; it is valid while mem_valid is high.

Function
REQ-026 The block SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE; req_ready SHALL be 1 only in IDLE.
REQ-027 In IDLE, when req_valid is 1, the block SHALL latch all req_* inputs and go to ISSUE, or to DONE if the access is misaligned or illegal.
REQ-028 A misaligned or illegal access SHALL be any of: half with addr[0]=1; word with addr[1:0]≠0; double with addr[2:0]≠0; size=3 with DATA_W=32.
REQ-029 For a misaligned or illegal access, mem_valid SHALL never assert, and DONE SHALL assert resp_misalign=1.
REQ-030 In ISSUE, mem_valid SHALL be 1; on mem_ready=1, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-031 In WAIT, on mem_rvalid=1, the block SHALL capture the extended data into resp_rdata and go to DONE.
REQ-032 mem_rvalid SHALL be ignored outside WAIT, including late data after a timeout.
REQ-033 The timeout counter SHALL clear on entry to ISSUE and on entry to WAIT.
REQ-034 After TIMEOUT consecutive cycles in ISSUE or WAIT without the awaited handshake, the block SHALL go to DONE with resp_timeout=1, and mem_valid SHALL drop.
REQ-035 DONE SHALL last one cycle with resp_valid=1 and then return to IDLE; a new request is accepted no earlier than the cycle after DONE.
REQ-036 resp_rdata SHALL hold its value until the next successful load; error responses SHALL leave it unchanged.
REQ-037 Latency with an immediate memory: a store gives resp_valid 2 cycles after acceptance; a load with mem_rvalid in the cycle after the handshake gives 3 cycles.
REQ-038 Byte enables SHALL be set as follows, with k = 1, 2, 4 or 8 bytes for size 0..3 and off = addr mod (DATA_W/8): mem_be has k ones starting at bit off, for both loads and stores.
REQ-039 mem_wdata SHALL be req_wdata's low k bytes shifted left by 8*off, with all other lanes 0.
REQ-040 Load data SHALL be mem_rdata shifted right by 8*off, then sign-extended from bit 8k-1, or zero-extended when req_unsigned=1; unsigned has no effect when k*8 = DATA_W.
REQ-041 mem_we, mem_be, mem_addr, mem_wdata and is_mmio SHALL be driven from latched registers and held stable throughout ISSUE.

Reset
REQ-042 When rst=1, the block SHALL force state IDLE and clear the counter and latches, asynchronously, including mid-ISSUE or mid-WAIT.
REQ-043 During and after reset: req_ready=1; resp_valid, resp_misalign, resp_timeout, mem_valid, mem_we and is_mmio = 0; mem_be, mem_addr, mem_wdata and resp_rdata = 0.
REQ-044 A transaction interrupted by reset SHALL produce no response.

Verification
REQ-045 LB at addr 0x103 with mem_rdata=0x80123456 -> mem_be=4'b1000, resp_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-046 SH at addr 0x102 with req_wdata=0x1234ABCD -> mem_addr=0x100, mem_be=4'b1100, mem_wdata=0xABCD0000, mem_we=1, resp_valid 2 cycles after acceptance.
REQ-047 LW at addr 0x106 -> mem_valid stays 0, resp_valid in the cycle after acceptance with resp_misalign=1, and resp_rdata unchanged.
REQ-048 TIMEOUT=4 with mem_ready held 0 -> mem_valid high for exactly 4 cycles, then resp_valid=1 with resp_timeout=1; a later mem_rvalid is ignored.
REQ-049 rst asserted in WAIT -> mem_valid=0 and req_ready=1 without waiting for a clock edge, and no resp_valid is produced; the next request completes normally.
REQ-050 SW at addr 0xFFFFFC60 -> is_mmio=1 during ISSUE; SW at addr 0x00000060 -> is_mmio=0.
